// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed 4-digit display scan controller.
// Drives the 2-bit scan index (I1, I0) into a one-hot digit-select decoder and
// presents the nibble and decimal point of the active digit. Each digit slot
// begins with a blanking dead-time. Display data is latched once per frame.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module digit_scan_ctrl #(
  parameter int CLK_DIV  = 1000,
  parameter int DEAD_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  output logic        I1,
  output logic        I0,
  output logic        sel_valid,
  output logic [3:0]  nibble_out,
  output logic        dp_out,
  output logic        frame_tick
);

  localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYC - 1);
  localparam logic [15:0] SHOW_LAST = 16'(CLK_DIV - DEAD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    SHOW
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        enter_dead;
  logic        latch_now;
  logic [15:0] lat_dig_q;
  logic [3:0]  lat_dp_q;
  logic [15:0] src_dig;
  logic [3:0]  src_dp;
  logic [3:0]  nib_next;
  logic        dp_next;
  logic [3:0]  nib_q;
  logic        dp_q;
  logic        show_blank;

  // Next-state logic: slot counter, scan index and DEAD-entry detection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    idx_d      = idx_q;
    enter_dead = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = DEAD;
          cnt_d      = '0;
          idx_d      = '0;
          enter_dead = 1'b1;
        end
        DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d    = DEAD;
            cnt_d      = '0;
            idx_d      = idx_q + 2'd1;
            enter_dead = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // A new frame begins whenever a slot for digit 0 is entered; fresh inputs
  // are forwarded straight to the output registers on that same edge.
  assign latch_now = enter_dead && (idx_d == 2'd0);
  assign src_dig   = latch_now ? digits_in : lat_dig_q;
  assign src_dp    = latch_now ? dp_in : lat_dp_q;
  assign nib_next  = src_dig[{idx_d, 2'b00} +: 4];
  assign dp_next   = src_dp[idx_d];

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is suppressed when it and every higher digit of the frame are zero.
  always_comb begin
    show_blank = 1'b0;
    unique case (idx_q)
      2'd3:    show_blank = (lat_dig_q[15:12] == 4'd0);
      2'd2:    show_blank = (lat_dig_q[15:8] == 8'd0);
      2'd1:    show_blank = (lat_dig_q[15:4] == 12'd0);
      default: show_blank = 1'b0;
    endcase
  end
`else
  assign show_blank = 1'b0;
`endif

  // State, counter, index, frame latch and per-slot output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      lat_dig_q <= '0;
      lat_dp_q  <= '0;
      nib_q     <= '0;
      dp_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (latch_now) begin
        lat_dig_q <= digits_in;
        lat_dp_q  <= dp_in;
      end
      if (enter_dead) begin
        nib_q <= nib_next;
        dp_q  <= dp_next;
      end else if (state_d == IDLE) begin
        nib_q <= '0;
        dp_q  <= 1'b0;
      end
    end
  end

  // The index only moves on DEAD entry, so it is stable whenever sel_valid=1.
  assign I1         = idx_q[1];
  assign I0         = idx_q[0];
  assign sel_valid  = (state_q == SHOW) && !show_blank;
  assign nibble_out = nib_q;
  assign dp_out     = dp_q;
  assign frame_tick = (state_q == SHOW) && (idx_q == 2'd3) && (cnt_q == SHOW_LAST);

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: self-checking bench for digit_scan_ctrl (CLK_DIV=8,
// DEAD_CYC=2). A time-based model derives the expected outputs from the
// position inside the frame; LEADING_ZERO_BLANK_EN is honoured if defined.
module tb_digit_scan_ctrl;

  localparam int CLK_DIV  = 8;
  localparam int DEAD_CYC = 2;
  localparam int FRAME    = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        I1;
  logic        I0;
  logic        sel_valid;
  logic [3:0]  nibble_out;
  logic        dp_out;
  logic        frame_tick;

  int compared   = 0;
  int mismatched = 0;

  // Model: whether the scan runs, cycle offset within the frame, frame data.
  bit          m_run = 1'b0;
  int          m_t   = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp  = '0;

  digit_scan_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .I1         (I1),
    .I0         (I0),
    .sel_valid  (sel_valid),
    .nibble_out (nibble_out),
    .dp_out     (dp_out),
    .frame_tick (frame_tick)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Advance the model by one rising edge using the inputs sampled at that edge.
  task automatic modelStep();
    if (!rst_n) begin
      m_run = 1'b0;
      m_t   = 0;
      m_dig = '0;
      m_dp  = '0;
    end else if (!en) begin
      m_run = 1'b0;
      m_t   = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_t   = 0;
      m_dig = digits_in;
      m_dp  = dp_in;
    end else begin
      m_t = (m_t + 1) % FRAME;
      if (m_t == 0) begin
        m_dig = digits_in;
        m_dp  = dp_in;
      end
    end
  endtask

  // One comparison: count it, and report it if it differs.
  task automatic compareField(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h (t=%0d run=%0d)", tag, obs, exp, m_t, m_run);
    end
  endtask

  // Expected outputs follow from the slot number and the phase inside the slot.
  task automatic checkOutput();
    int          idx;
    int          phase;
    logic [15:0] upper;
    logic [3:0]  e_nib;
    logic        e_dp;
    logic        e_sel;
    logic        e_tick;
    logic [1:0]  e_idx;
    e_idx  = 2'd0;
    e_nib  = 4'd0;
    e_dp   = 1'b0;
    e_sel  = 1'b0;
    e_tick = 1'b0;
    if (m_run) begin
      idx    = m_t / CLK_DIV;
      phase  = m_t % CLK_DIV;
      upper  = m_dig >> (4 * idx);
      e_idx  = 2'(idx);
      e_nib  = upper[3:0];
      e_dp   = m_dp[idx];
      e_sel  = (phase >= DEAD_CYC);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx > 0 && upper == 16'd0) e_sel = 1'b0;
`endif
      e_tick = (idx == 3) && (phase == CLK_DIV - 1);
    end
    compareField("I1", {3'b000, I1}, {3'b000, e_idx[1]});
    compareField("I0", {3'b000, I0}, {3'b000, e_idx[0]});
    compareField("sel_valid", {3'b000, sel_valid}, {3'b000, e_sel});
    compareField("nibble_out", nibble_out, e_nib);
    compareField("dp_out", {3'b000, dp_out}, {3'b000, e_dp});
    compareField("frame_tick", {3'b000, frame_tick}, {3'b000, e_tick});
  endtask

  // Drive inputs on the falling edge, then check #1 after the rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [15:0] d,
                               input logic [3:0] p, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst_n     = r;
      en        = e;
      digits_in = d;
      dp_in     = p;
      @(posedge clk);
      #1;
      modelStep();
      checkOutput();
    end
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    logic [15:0] rd;
    rst_n     = 1'b0;
    en        = 1'b1;
    digits_in = 16'h4321;
    dp_in     = 4'b0100;

    $display("[TB] reset and idle");
    applyStimulus(1'b0, 1'b1, 16'h4321, 4'b0100, 3);
    applyStimulus(1'b1, 1'b0, 16'h4321, 4'b0100, 20);

    $display("[TB] nominal scan and tearing");
    applyStimulus(1'b1, 1'b1, 16'h4321, 4'b0100, 43);
    applyStimulus(1'b1, 1'b1, 16'h8765, 4'b0100, 40);

    $display("[TB] enable drop during idx 2 show");
    applyStimulus(1'b1, 1'b0, 16'h8765, 4'b0100, 2);
    applyStimulus(1'b1, 1'b1, 16'h8765, 4'b0100, 60);

    $display("[TB] reset during idx 3 show");
    applyStimulus(1'b1, 1'b1, 16'h8765, 4'b1001, 1);
    applyStimulus(1'b0, 1'b1, 16'h8765, 4'b1001, 1);
    applyStimulus(1'b1, 1'b1, 16'h8765, 4'b1001, 40);

    $display("[TB] leading zero digits");
    applyStimulus(1'b1, 1'b1, 16'h0050, 4'b0000, 70);
    applyStimulus(1'b1, 1'b1, 16'h0000, 4'b0001, 40);
    applyStimulus(1'b1, 1'b1, 16'h0300, 4'b0010, 40);

    $display("[TB] randomized run");
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) begin
        rd[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      end
      applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 79) != 0),
                    rd, 4'($urandom), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
